profiler_axil_counter_slave: RTL and testbench
==============================================

Name: profiler_axil_counter_slave

Overview:
- AXI4-Lite slave that terminates the profiler master-VIP port and owns the profiler's event/cycle counters, control bits and threshold interrupt.
- It sits directly downstream of the AXI4-Lite master driving each profiler slave port (S00/S01). One instance is used per port.
- Software starts and stops counting, clears, snapshots and reads back counts through four 32-bit registers.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; decodes 4 word registers using addr[3:2].
- CNT_WIDTH, 32, live counter width, 1..32; it is zero-extended on readback.

Ports:
- ACLK  in  1  clock
- ARESET  in  1  asynchronous active-high reset
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address; S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID in 1; S_AXI_AWREADY out 1
- S_AXI_WDATA  in  32; S_AXI_WSTRB  in  4; S_AXI_WVALID in 1; S_AXI_WREADY out 1
- S_AXI_BRESP  out  2; S_AXI_BVALID out 1; S_AXI_BREADY in 1
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH; S_AXI_ARPROT in 3 ignored; S_AXI_ARVALID in 1; S_AXI_ARREADY out 1
- S_AXI_RDATA  out  32; S_AXI_RRESP  out  2; S_AXI_RVALID out 1; S_AXI_RREADY in 1
- event_i  in  1  monitored event strobe, synchronous to ACLK
- irq_o  out  1  level threshold interrupt

Behaviour:
- Reset (async assert, sync release):
  - AWREADY=WREADY=ARREADY=0 while ARESET is high; all three go to 1 on the first ACLK edge after release.
  - BVALID=RVALID=0, BRESP=RRESP=00, RDATA=0, irq_o=0.
  - All registers and counters are cleared to 0.
  - An outstanding transaction is dropped with no response.
- Register map:
  - 0x0 CTRL:
    - bit0 ENABLE: read/write.
    - bit1 CLEAR: write-1 pulse, reads 0.
    - bit2 SNAP: write-1 pulse, reads 0.
    - bit3 IRQ_STICKY: read; write-1 clears it.
    - All other bits read 0.
  - 0x4 THRESH: read/write, 32 bits, honours WSTRB per byte lane.
  - 0x8 CYC_SNAP: read-only.
  - 0xC EVT_SNAP: read-only.
  - Writes to read-only registers are ignored and return OKAY. All responses are OKAY (00).
- Write path:
  - AW and W are accepted independently, in either order. AWREADY is high while no address is held and BVALID=0; WREADY likewise for data.
  - Once both address and data are held, the register update commits on the next edge and BVALID rises on that same edge.
  - BVALID holds until BREADY. AWREADY/WREADY stay 0 until the B handshake completes.
  - Throughput: at most 1 write per 2 cycles.
- Read path:
  - ARREADY=!RVALID.
  - After the AR handshake, RVALID and RDATA are registered on the next edge (latency 1).
  - RDATA holds stable until RREADY.
  - If a read and a write commit to the same register on the same edge, the read returns the pre-write value.
- Counters:
  - cyc_cnt increments every cycle while ENABLE=1.
  - evt_cnt increments on cycles where ENABLE=1 and event_i=1.
  - Both saturate at 2^CNT_WIDTH-1; there is no wrap.
  - A CLEAR commit zeros both counters on the commit edge; clear has priority over increment.
  - A SNAP commit copies the live counts, i.e. the values before that edge's increment, into CYC_SNAP/EVT_SNAP.
  - If SNAP and CLEAR are in the same write, the snapshot captures the pre-clear values.
- Interrupt:
  - IRQ_STICKY is set on the edge where THRESH!=0, ENABLE=1 and the updated evt_cnt >= THRESH.
  - irq_o = IRQ_STICKY, registered.
  - A W1C on bit3 clears it. If the set condition is still true on that same edge, set wins.
  - CLEAR does not clear IRQ_STICKY.

Decomposition:
- Package profiler_pkg holds:
  - Register offsets: ADDR_CTRL=2'd0, ADDR_THRESH=2'd1, ADDR_CYC=2'd2, ADDR_EVT=2'd3.
  - CTRL bit indices.
  - The AXI_RESP_OKAY constant.
- Sub-module profiler_counter_unit holds:
  - The saturating cyc/evt counters, snapshot registers and IRQ sticky logic.
  - Inputs: enable, clear_pulse, snap_pulse, irq_w1c, thresh, event_i. Outputs: snapshots and irq.
- The top level contains only the AXI4-Lite channel FSMs and the register decode.

Test Plan:
1. Release reset, then idle 5 cycles → AWREADY=WREADY=ARREADY=1, BVALID=RVALID=irq_o=0; reads of 0x0/0x4/0x8/0xC all return 0x00000000 with RRESP=00.
2. Write 0x4=0xA5A5A5A5 with WSTRB=0xF, then 0x4=0x000000FF with WSTRB=0x1 → read 0x4=0xA5A5A5FF; write 0x8=0xDEADBEEF → BRESP=00, read 0x8=0.
3. Write CTRL=0x1, pulse event_i for exactly 10 cycles, write CTRL=0x0, then CTRL=0x4 → EVT_SNAP=10; CYC_SNAP equals the enabled-cycle count from the ENABLE commit edge to the disable commit edge.
4. With THRESH=5 and CTRL=0x1, drive 5 events → irq_o rises on the edge counting the 5th event and CTRL reads 0x9; write CTRL=0x9 with event_i=0 and evt_cnt reset via CLEAR first → irq_o=0.
5. Present W 3 cycles before AW, and hold BREADY=0 for 20 cycles → BVALID stays 1 and AWREADY=WREADY=0 throughout; one write commits; BVALID drops the cycle after BREADY=1.
6. With CNT_WIDTH=8 and ENABLE=1 for 300 cycles, then SNAP → CYC_SNAP=0x000000FF; assert ARESET while RVALID=1 → RVALID=0 and irq_o=0 immediately, and counters read 0 after release.

Source files
------------

// File: rtl/profiler_pkg.sv
// Shared constants and state types for the profiler AXI4-Lite counter slave.
package profiler_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_THRESH = 2'd1;
  localparam logic [1:0] ADDR_CYC    = 2'd2;
  localparam logic [1:0] ADDR_EVT    = 2'd3;

  localparam int unsigned CTRL_ENABLE = 0;
  localparam int unsigned CTRL_CLEAR  = 1;
  localparam int unsigned CTRL_SNAP   = 2;
  localparam int unsigned CTRL_IRQ    = 3;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    WrIdle,
    WrHaveAddr,
    WrHaveData,
    WrCommit,
    WrResp
  } wr_state_e;

  typedef enum logic {
    RdIdle,
    RdResp
  } rd_state_e;

endpackage

// File: rtl/profiler_counter_unit.sv
// Saturating cycle/event counters, snapshot registers and sticky threshold interrupt.
module profiler_counter_unit
  import profiler_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        clear_pulse,
  input  logic        snap_pulse,
  input  logic        irq_w1c,
  input  logic [31:0] thresh,
  input  logic        event_i,
  output logic [31:0] cyc_snap,
  output logic [31:0] evt_snap,
  output logic        irq
);

  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
  logic [CNT_WIDTH-1:0] evt_q, evt_d;
  logic [CNT_WIDTH-1:0] cyc_snap_q, cyc_snap_d;
  logic [CNT_WIDTH-1:0] evt_snap_q, evt_snap_d;
  logic                 irq_q, irq_d;

  always_comb begin
    cyc_d      = cyc_q;
    evt_d      = evt_q;
    cyc_snap_d = cyc_snap_q;
    evt_snap_d = evt_snap_q;
    irq_d      = irq_q;

    if (enable) begin
      if (cyc_q != CntMax) cyc_d = cyc_q + 1'b1;
      if (event_i && (evt_q != CntMax)) evt_d = evt_q + 1'b1;
    end
    if (clear_pulse) begin
      cyc_d = '0;
      evt_d = '0;
    end

    // Snapshot takes the live counts before this edge's increment or clear.
    if (snap_pulse) begin
      cyc_snap_d = cyc_q;
      evt_snap_d = evt_q;
    end

    // Set is evaluated after the W1C so a still-true condition wins.
    if (irq_w1c) irq_d = 1'b0;
    if ((thresh != 32'd0) && enable && (32'(evt_d) >= thresh)) irq_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q      <= '0;
      evt_q      <= '0;
      cyc_snap_q <= '0;
      evt_snap_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      cyc_q      <= cyc_d;
      evt_q      <= evt_d;
      cyc_snap_q <= cyc_snap_d;
      evt_snap_q <= evt_snap_d;
      irq_q      <= irq_d;
    end
  end

  assign cyc_snap = 32'(cyc_snap_q);
  assign evt_snap = 32'(evt_snap_q);
  assign irq      = irq_q;

endmodule

// File: rtl/profiler_axil_counter_slave.sv
// AXI4-Lite slave exposing the profiler CTRL/THRESH/snapshot registers; one instance per port.
module profiler_axil_counter_slave
  import profiler_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned CNT_WIDTH          = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            event_i,
  output logic                            irq_o
);

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic        arready_q, arready_d;
  logic        aw_hs, w_hs, ar_hs;

  logic [1:0]  aw_addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic        enable_q, enable_d;
  logic [31:0] thresh_q, thresh_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] rd_mux, ctrl_rd;

  logic        wr_commit, ctrl_wr;
  logic        clear_pulse, snap_pulse, irq_w1c;
  logic [31:0] cyc_snap, evt_snap;
  logic        irq;

  logic        unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  assign aw_hs = S_AXI_AWVALID && awready_q;
  assign w_hs  = S_AXI_WVALID && wready_q;
  assign ar_hs = S_AXI_ARVALID && arready_q;

  // Write channel: AW and W may arrive in either order; commit one edge after both are held.
  always_comb begin
    wr_state_d = wr_state_q;
    unique case (wr_state_q)
      WrIdle: begin
        if (aw_hs && w_hs) wr_state_d = WrCommit;
        else if (aw_hs)    wr_state_d = WrHaveAddr;
        else if (w_hs)     wr_state_d = WrHaveData;
      end
      WrHaveAddr: if (w_hs) wr_state_d = WrCommit;
      WrHaveData: if (aw_hs) wr_state_d = WrCommit;
      WrCommit:   wr_state_d = WrResp;
      WrResp:     if (S_AXI_BREADY) wr_state_d = WrIdle;
      default:    wr_state_d = WrIdle;
    endcase
    awready_d = (wr_state_d == WrIdle) || (wr_state_d == WrHaveData);
    wready_d  = (wr_state_d == WrIdle) || (wr_state_d == WrHaveAddr);
  end

  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      RdIdle:  if (ar_hs) rd_state_d = RdResp;
      RdResp:  if (S_AXI_RREADY) rd_state_d = RdIdle;
      default: rd_state_d = RdIdle;
    endcase
    arready_d = (rd_state_d == RdIdle);
  end

  assign wr_commit   = (wr_state_q == WrCommit);
  assign ctrl_wr     = wr_commit && (aw_addr_q == ADDR_CTRL) && wstrb_q[0];
  assign clear_pulse = ctrl_wr && wdata_q[CTRL_CLEAR];
  assign snap_pulse  = ctrl_wr && wdata_q[CTRL_SNAP];
  assign irq_w1c     = ctrl_wr && wdata_q[CTRL_IRQ];

  always_comb begin
    enable_d = enable_q;
    thresh_d = thresh_q;
    if (ctrl_wr) enable_d = wdata_q[CTRL_ENABLE];
    if (wr_commit && (aw_addr_q == ADDR_THRESH)) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) thresh_d[8*i +: 8] = wdata_q[8*i +: 8];
      end
    end
  end

  // Read data is sampled from pre-commit register values on the AR handshake edge.
  always_comb begin
    ctrl_rd              = '0;
    ctrl_rd[CTRL_ENABLE] = enable_q;
    ctrl_rd[CTRL_IRQ]    = irq;
    rd_mux               = '0;
    unique case (S_AXI_ARADDR[3:2])
      ADDR_CTRL:   rd_mux = ctrl_rd;
      ADDR_THRESH: rd_mux = thresh_q;
      ADDR_CYC:    rd_mux = cyc_snap;
      ADDR_EVT:    rd_mux = evt_snap;
      default:     rd_mux = '0;
    endcase
    rdata_d = ar_hs ? rd_mux : rdata_q;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state_q <= WrIdle;
      rd_state_q <= RdIdle;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      arready_q  <= 1'b0;
      aw_addr_q  <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      enable_q   <= 1'b0;
      thresh_q   <= '0;
      rdata_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      arready_q  <= arready_d;
      if (aw_hs) aw_addr_q <= S_AXI_AWADDR[3:2];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      enable_q   <= enable_d;
      thresh_q   <= thresh_d;
      rdata_q    <= rdata_d;
    end
  end

  profiler_counter_unit #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_counter_unit (
    .clk         (ACLK),
    .rst         (ARESET),
    .enable      (enable_q),
    .clear_pulse (clear_pulse),
    .snap_pulse  (snap_pulse),
    .irq_w1c     (irq_w1c),
    .thresh      (thresh_q),
    .event_i     (event_i),
    .cyc_snap    (cyc_snap),
    .evt_snap    (evt_snap),
    .irq         (irq)
  );

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_BVALID  = (wr_state_q == WrResp);
  assign S_AXI_BRESP   = AXI_RESP_OKAY;
  assign S_AXI_RVALID  = (rd_state_q == RdResp);
  assign S_AXI_RRESP   = AXI_RESP_OKAY;
  assign S_AXI_RDATA   = rdata_q;
  assign irq_o         = irq;

endmodule

// File: tb/tb_profiler_axil_counter_slave.sv
// Directed plus randomized bench for the profiler AXI4-Lite slave against a cycle-level model.
module tb_profiler_axil_counter_slave;

  localparam int unsigned CntW   = 8;
  localparam int unsigned CntMax = (1 << CntW) - 1;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [3:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [3:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic        event_i = 1'b0;
  logic        irq_o;

  int checks = 0;
  int errors = 0;

  profiler_axil_counter_slave #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (4),
    .CNT_WIDTH          (CntW)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .event_i       (event_i),
    .irq_o         (irq_o)
  );

  always #5 ACLK = ~ACLK;

  // Reference model: architectural state advanced once per clock from the register-map rules.
  int unsigned m_cyc = 0, m_evt = 0, m_cs = 0, m_es = 0;
  logic        m_en = 1'b0, m_sticky = 1'b0;
  logic [31:0] m_thr = '0;
  logic        m_commit = 1'b0;
  logic [3:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic [3:0]  m_strb = '0;

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      m_cyc <= 0; m_evt <= 0; m_cs <= 0; m_es <= 0;
      m_en <= 1'b0; m_sticky <= 1'b0; m_thr <= '0;
    end else begin : model_step
      int unsigned n_cyc, n_evt, n_cs, n_es;
      logic        n_en, n_sticky;
      logic [31:0] n_thr;
      n_cyc = m_cyc; n_evt = m_evt; n_cs = m_cs; n_es = m_es;
      n_en = m_en; n_sticky = m_sticky; n_thr = m_thr;
      if (m_en) begin
        n_cyc = (m_cyc == CntMax) ? m_cyc : m_cyc + 1;
        if (event_i) n_evt = (m_evt == CntMax) ? m_evt : m_evt + 1;
      end
      if (m_commit && m_addr[3:2] == 2'd0 && m_strb[0]) begin
        n_en = m_data[0];
        if (m_data[2]) begin n_cs = m_cyc; n_es = m_evt; end
        if (m_data[1]) begin n_cyc = 0; n_evt = 0; end
        if (m_data[3]) n_sticky = 1'b0;
      end
      if (m_commit && m_addr[3:2] == 2'd1) begin
        for (int i = 0; i < 4; i++) if (m_strb[i]) n_thr[8*i +: 8] = m_data[8*i +: 8];
      end
      if (m_thr != 0 && m_en && n_evt >= m_thr) n_sticky = 1'b1;
      m_cyc <= n_cyc; m_evt <= n_evt; m_cs <= n_cs; m_es <= n_es;
      m_en <= n_en; m_sticky <= n_sticky; m_thr <= n_thr;
    end
  end

  function automatic logic [31:0] model_read(input logic [3:0] addr);
    case (addr[3:2])
      2'd0:    return {28'd0, m_sticky, 2'b00, m_en};
      2'd1:    return m_thr;
      2'd2:    return m_cs;
      default: return m_es;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge ACLK) begin
    if (!ARESET) check("irq_level", irq_o, m_sticky);
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int w_lead, input int b_hold);
    bit aw_done, w_done, aw_hs, w_hs;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    m_addr = addr; m_data = data; m_strb = strb;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_WVALID = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      if (n >= w_lead && !aw_done) S_AXI_AWVALID = 1'b1;
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      tick();
      if (aw_hs) begin aw_done = 1; S_AXI_AWVALID = 1'b0; end
      if (w_hs) begin w_done = 1; S_AXI_WVALID = 1'b0; end
      n++;
    end
    check("wr_handshake", {aw_done, w_done}, 2'b11);
    m_commit = 1'b1;
    tick();
    m_commit = 1'b0;
    check("bvalid_rise", S_AXI_BVALID, 1'b1);
    check("bresp", S_AXI_BRESP, 2'b00);
    check("aw_w_ready_busy", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b00);
    for (int i = 0; i < b_hold; i++) begin
      tick();
      check("bvalid_hold", S_AXI_BVALID, 1'b1);
      check("ready_hold", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b00);
    end
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    check("bvalid_drop", S_AXI_BVALID, 1'b0);
    check("ready_back", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
  endtask

  task automatic do_read(input logic [3:0] addr, input int r_hold, output logic [31:0] got);
    logic [31:0] exp;
    bit hs;
    int n;
    hs = 0; n = 0; exp = '0;
    S_AXI_ARADDR = addr;
    S_AXI_ARVALID = 1'b1;
    while (!hs && n < 50) begin
      hs = S_AXI_ARREADY;
      exp = model_read(addr);
      tick();
      n++;
    end
    S_AXI_ARVALID = 1'b0;
    check("rd_handshake", hs, 1'b1);
    got = S_AXI_RDATA;
    check("rvalid_rise", S_AXI_RVALID, 1'b1);
    check("rdata", S_AXI_RDATA, exp);
    check("rresp", S_AXI_RRESP, 2'b00);
    for (int i = 0; i < r_hold; i++) begin
      tick();
      check("rdata_stable", S_AXI_RDATA, exp);
      check("arready_busy", S_AXI_ARREADY, 1'b0);
    end
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;
    check("rvalid_drop", S_AXI_RVALID, 1'b0);
  endtask

  initial begin
    logic [31:0] rd;
    // Reset behaviour
    repeat (3) @(posedge ACLK);
    #1;
    check("ready_in_reset", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    #2 ARESET = 1'b0;
    tick();
    check("ready_after_release", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    repeat (5) tick();
    check("idle_valids", {S_AXI_BVALID, S_AXI_RVALID, irq_o}, 3'b000);
    for (int a = 0; a < 4; a++) begin
      do_read(4'(a * 4), 0, rd);
      check("reset_reg_zero", rd, 32'd0);
    end

    // THRESH byte-lane writes and read-only register writes
    do_write(4'h4, 32'hA5A5A5A5, 4'hF, 0, 0);
    do_write(4'h4, 32'h000000FF, 4'h1, 0, 0);
    do_read(4'h4, 1, rd);
    check("thresh_merge", rd, 32'hA5A5A5FF);
    do_write(4'h8, 32'hDEADBEEF, 4'hF, 0, 0);
    do_read(4'h8, 0, rd);
    check("ro_write_ignored", rd, 32'd0);

    // Event counting with snapshot
    do_write(4'h0, 32'h1, 4'hF, 0, 0);
    repeat (10) begin event_i = 1'b1; tick(); end
    event_i = 1'b0;
    repeat (3) tick();
    do_write(4'h0, 32'h0, 4'hF, 0, 0);
    do_write(4'h0, 32'h4, 4'hF, 0, 0);
    do_read(4'hC, 0, rd);
    check("evt_snap_10", rd, 32'd10);
    do_read(4'h8, 2, rd);
    do_read(4'h0, 0, rd);
    check("ctrl_bits_read_zero", rd, 32'd0);

    // Threshold interrupt, set-wins on W1C, CLEAR keeps sticky
    do_write(4'h4, 32'd5, 4'hF, 0, 0);
    do_write(4'h0, 32'h3, 4'hF, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      event_i = 1'b1;
      tick();
      check("irq_at_event", irq_o, (k == 5) ? 1'b1 : 1'b0);
    end
    event_i = 1'b0;
    do_read(4'h0, 0, rd);
    check("ctrl_irq_read", rd, 32'h9);
    do_write(4'h0, 32'h9, 4'hF, 0, 0);
    check("irq_set_wins", irq_o, 1'b1);
    do_write(4'h0, 32'h3, 4'hF, 0, 0);
    check("irq_survives_clear", irq_o, 1'b1);
    do_write(4'h0, 32'h9, 4'hF, 0, 0);
    check("irq_w1c", irq_o, 1'b0);

    // W ahead of AW with long B backpressure
    do_write(4'h0, 32'h0, 4'hF, 0, 0);
    do_write(4'h4, 32'h12345678, 4'hF, 3, 20);
    do_read(4'h4, 0, rd);
    check("late_aw_commit", rd, 32'h12345678);

    // Saturation, then reset while a read response is pending
    do_write(4'h4, 32'd3, 4'hF, 0, 0);
    do_write(4'h0, 32'h3, 4'hF, 0, 0);
    for (int c = 0; c < 300; c++) begin
      event_i = (c < 5) ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
    end
    event_i = 1'b0;
    do_write(4'h0, 32'h5, 4'hF, 0, 0);
    do_read(4'h8, 0, rd);
    check("cyc_saturated", rd, 32'h000000FF);
    do_read(4'hC, 0, rd);
    check("irq_before_reset", irq_o, 1'b1);
    S_AXI_ARADDR = 4'h8;
    S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_ARVALID = 1'b0;
    check("rvalid_pre_reset", S_AXI_RVALID, 1'b1);
    ARESET = 1'b1;
    #1;
    check("reset_async", {S_AXI_RVALID, irq_o, S_AXI_BVALID}, 3'b000);
    check("reset_ready_low", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    #1 ARESET = 1'b0;
    tick();
    check("ready_after_rerelease", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    do_write(4'h0, 32'h4, 4'hF, 0, 0);
    do_read(4'h8, 0, rd);
    check("cyc_after_reset", rd, 32'd0);
    do_read(4'hC, 0, rd);
    check("evt_after_reset", rd, 32'd0);

    // Randomized traffic against the model
    for (int it = 0; it < 60; it++) begin
      int op;
      event_i = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) tick();
      op = $urandom_range(0, 3);
      case (op)
        0: do_write(4'h0, 32'($urandom_range(0, 15)), 4'hF, $urandom_range(0, 2),
                    $urandom_range(0, 2));
        1: do_write(4'h4, 32'($urandom_range(0, 20)), 4'($urandom_range(1, 15)),
                    $urandom_range(0, 2), $urandom_range(0, 2));
        default: do_read(4'($urandom_range(0, 3) * 4), $urandom_range(0, 2), rd);
      endcase
    end
    event_i = 1'b0;
    do_write(4'h0, 32'h4, 4'hF, 0, 0);
    do_read(4'h8, 0, rd);
    do_read(4'hC, 0, rd);
    do_read(4'h0, 0, rd);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
